// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache.
//
// Hits are answered combinationally from the frame arrays. A miss latches
// the word address and runs a single-word fill over the iREN/iwait handshake.
// The instruction is then served from the new frame on the following cycle.
//
// Ports
//   CLK, RST     clock; synchronous active-high reset
//   imemREN      datapath instruction read request
//   imemaddr     datapath byte address (bits [1:0] ignored)
//   ihit         imemload is valid this cycle
//   imemload     instruction word (0 when not hitting)
//   flush        invalidate every frame at the next edge
//   iREN         memory read request (FETCH only)
//   iaddr        memory word address (always the latched fetch address)
//   iwait        memory busy; iload is valid when iREN && !iwait
//   iload        memory read data
//   hit_count    number of cycles with ihit=1 (wraps)
//   miss_count   number of completed fills (wraps)
//
// Handshake: a fill request is held (iREN=1, iaddr stable) from the first
// FETCH cycle until a rising edge that sees iwait=0. At that edge iload is
// captured and the request drops. A reset abandons the request.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t state, next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];
    logic [31:0]      fetch_addr;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit_cond;
    logic             start_fill;
    logic             fill_done;

    // Byte-offset bits carry no information for a word-wide cache.
    logic unused_offset;
    assign unused_offset = ^imemaddr[1:0];

    assign idx      = imemaddr[2 +: IDX_W];
    assign tag      = imemaddr[31 -: TAG_W];
    assign fill_idx = fetch_addr[2 +: IDX_W];
    assign fill_tag = fetch_addr[31 -: TAG_W];

    // A flush cycle never hits: the invalidation takes precedence.
    assign hit_cond = imemREN && valid[idx] && (tag_mem[idx] == tag) && !flush;

    assign iaddr = fetch_addr;

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = 32'd0;
        iREN       = 1'b0;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                if (hit_cond) begin
                    ihit     = 1'b1;
                    imemload = data_mem[idx];
                end else if (imemREN && !flush) begin
                    start_fill = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            fetch_addr <= 32'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            state <= next_state;
            if (start_fill)
                fetch_addr <= {imemaddr[31:2], 2'b00};
            if (fill_done) begin
                valid[fill_idx] <= !flush;
                miss_count      <= miss_count + 32'd1;
            end
            // Placed after the fill so a same-cycle flush also clears the new frame.
            if (flush)
                valid <= '0;
            if (ihit)
                hit_count <= hit_count + 32'd1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (!RST && fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    logic        clk;
    logic        rst;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache #(.SETS(16)) dut (
        .CLK        (clk),
        .RST        (rst),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hits   = 32'd0;
    logic [31:0] exp_misses = 32'd0;

    typedef struct {
        logic [31:0] addr;
        int          w;
        bit          miss;
    } vec_t;

    vec_t vecs[14];

    // Memory contents seen by the fill port (word address in).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)  return 32'h2001000A;
        if (a == 32'h40) return 32'h8C220004;
        return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_hit_count"},  hit_count,  exp_hits);
        chk({name, "_miss_count"}, miss_count, exp_misses);
    endtask

    // ---------------- driver tasks ----------------
    // One read transaction, acting as the memory controller when a fill occurs.
    task automatic do_read(input logic [31:0] addr, input int w, input bit exp_miss,
                           input string name);
        logic [31:0] wa;
        wa = {addr[31:2], 2'b00};
        exp_q.push_back(mem_word(wa));
        @(negedge clk);
        imemREN = 1'b1; imemaddr = addr; iwait = 1'b0; flush = 1'b0;
        #1;
        chk_cnt(name);
        chk({name, "_idle_iren"}, {31'd0, iREN}, 32'd0);
        if (exp_miss) begin
            chk({name, "_miss_ihit"}, {31'd0, ihit}, 32'd0);
            for (int k = 0; k <= w; k++) begin
                @(negedge clk);
                iwait = (k < w);
                iload = (k < w) ? 32'hDEADBEEF : mem_word(wa);
                #1;
                chk({name, "_fetch_iren"},  {31'd0, iREN}, 32'd1);
                chk({name, "_fetch_iaddr"}, iaddr, wa);
                chk({name, "_fetch_ihit"},  {31'd0, ihit}, 32'd0);
            end
            exp_misses++;
            @(negedge clk);
            iwait = 1'b0; iload = 32'd0;
            #1;
            chk({name, "_post_iren"}, {31'd0, iREN}, 32'd0);
            chk_cnt({name, "_post"});
        end
        chk({name, "_ihit"}, {31'd0, ihit}, 32'd1);
        if (exp_q.size() > 0)
            chk({name, "_imemload"}, imemload, exp_q.pop_front());
        exp_hits++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; flush = 1'b0;
        iwait = 1'b0; iload = 32'd0;

        vecs[0]  = '{32'h0000_0000, 2, 1'b1};
        vecs[1]  = '{32'h0000_0000, 0, 1'b0};
        vecs[2]  = '{32'h0000_0000, 0, 1'b0};
        vecs[3]  = '{32'h0000_0000, 0, 1'b0};
        vecs[4]  = '{32'h0000_0040, 0, 1'b1};
        vecs[5]  = '{32'h0000_0000, 1, 1'b1};
        vecs[6]  = '{32'h0000_0004, 0, 1'b1};
        vecs[7]  = '{32'h0000_0007, 0, 1'b0};
        vecs[8]  = '{32'h1000_0008, int'($urandom_range(0, 3)), 1'b1};
        vecs[9]  = '{32'h0000_0008, 0, 1'b1};
        vecs[10] = '{32'h1000_0008, int'($urandom_range(0, 3)), 1'b1};
        vecs[11] = '{32'h0000_003C, int'($urandom_range(0, 3)), 1'b1};
        vecs[12] = '{32'h0000_003E, 0, 1'b0};
        vecs[13] = '{32'h0000_0000, 0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ihit",     {31'd0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iren",     {31'd0, iREN}, 32'd0);
        chk("rst_iaddr",    iaddr, 32'd0);
        chk_cnt("rst");

        // Idle cycle with no request
        @(negedge clk);
        imemREN = 1'b0; imemaddr = 32'h0000_0040;
        #1;
        chk("noreq_ihit",     {31'd0, ihit}, 32'd0);
        chk("noreq_imemload", imemload, 32'd0);
        chk("noreq_iren",     {31'd0, iREN}, 32'd0);

        // Table-driven reads
        for (int i = 0; i < 14; i++)
            do_read(vecs[i].addr, vecs[i].w, vecs[i].miss, $sformatf("vec%0d", i));

        // Flush coincident with a hit: flush wins, no fill starts
        @(negedge clk);
        imemREN = 1'b1; imemaddr = 32'h4; flush = 1'b1;
        #1;
        chk("flush_ihit",     {31'd0, ihit}, 32'd0);
        chk("flush_imemload", imemload, 32'd0);
        chk_cnt("flush");
        do_read(32'h4, 0, 1'b1, "flush_refill");

        // Flush during the fill-completing cycle leaves the frame invalid
        @(negedge clk);
        imemREN = 1'b1; imemaddr = 32'hC; flush = 1'b0;
        #1;
        chk("ff_miss_ihit", {31'd0, ihit}, 32'd0);
        @(negedge clk);
        iwait = 1'b0; iload = mem_word(32'hC); flush = 1'b1;
        #1;
        chk("ff_iren", {31'd0, iREN}, 32'd1);
        exp_misses++;
        do_read(32'hC, 1, 1'b1, "fill_flush");

        // Address change during FETCH: fetch address is held
        @(negedge clk);
        imemREN = 1'b1; imemaddr = 32'h4;
        #1;
        chk("chg_miss_ihit", {31'd0, ihit}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            iwait = 1'b1; imemaddr = 32'h8;
            #1;
            chk("chg_iaddr", iaddr, 32'h4);
            chk("chg_iren",  {31'd0, iREN}, 32'd1);
        end
        @(negedge clk);
        iwait = 1'b0; iload = mem_word(32'h4);
        #1;
        chk("chg_last_iaddr", iaddr, 32'h4);
        exp_misses++;
        do_read(32'h8, 0, 1'b1, "after_change");
        do_read(32'h4, 0, 1'b0, "frame1_filled");

        // Reset in the middle of a fill
        @(negedge clk);
        imemREN = 1'b1; imemaddr = 32'h100;
        #1;
        chk("rf_miss_ihit", {31'd0, ihit}, 32'd0);
        @(negedge clk);
        iwait = 1'b1;
        #1;
        chk("rf_iaddr", iaddr, 32'h100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; imemREN = 1'b0; iwait = 1'b0;
        #1;
        exp_hits = 32'd0; exp_misses = 32'd0;
        chk("rf_iren",  {31'd0, iREN}, 32'd0);
        chk("rf_iaddr0", iaddr, 32'd0);
        chk("rf_ihit",  {31'd0, ihit}, 32'd0);
        chk_cnt("rf");
        do_read(32'h4, int'($urandom_range(0, 2)), 1'b1, "post_reset");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-block instruction cache between the datapath's instruction port and the memory controller. It returns `ihit`/`imemload` in the same cycle for hits. On a miss it runs a single-word fill over an `iREN`/`iwait` handshake, then serves the instruction from the newly installed frame. It also keeps hit and miss counters for performance reporting.

## Interface
- `SETS`, 16, number of frames; power of two, 2..64; `IDX_W = log2(SETS)`, `TAG_W = 30 - IDX_W`
- `CLK`  in  1  clock, all state updates on rising edge
- `RST`  in  1  reset; one clock; reset is synchronous and active-high
- `imemREN`  in  1  datapath instruction read request
- `imemaddr`  in  32  datapath instruction byte address
- `ihit`  out  1  `imemload` valid this cycle
- `imemload`  out  32  instruction word
- `flush`  in  1  invalidate all frames
- `iREN`  out  1  memory read request
- `iaddr`  out  32  memory word address, `[1:0]` always 0
- `iwait`  in  1  memory busy; `iload` valid when `iREN && !iwait`
- `iload`  in  32  memory read data
- `hit_count`  out  32  cycles with `ihit=1`
- `miss_count`  out  32  completed fills

## Operation
- Address split:
  - `[1:0]` ignored.
  - index = `imemaddr[2 +: IDX_W]`.
  - tag = `imemaddr[31 : 2+IDX_W]`.
- Each frame holds `valid`, `tag[TAG_W]` and `data[32]`.
- States: IDLE, FETCH.
- IDLE behaviour:
  - A hit is `imemREN && valid[idx] && tag[idx]==tag && !flush`. On a hit: `ihit=1` and `imemload=data[idx]`, both combinational.
  - A miss is `imemREN` and not a hit, excluding a flush cycle. On a miss: latch `fetch_addr <= {imemaddr[31:2],2'b00}` and go to FETCH. `ihit=0`.
  - When `imemREN=0`: `ihit=0` and `imemload=0`.
- FETCH behaviour:
  - `iREN=1` and `iaddr=fetch_addr`.
  - `ihit=0` and `imemload=0`.
  - While `iwait=1`, stay in FETCH.
  - When `iwait=0`:
    - write the frame at `fetch_addr`'s index with `data=iload`, `tag` from `fetch_addr`, and `valid=1` (or `valid=0` if `flush` is asserted this same cycle);
    - increment `miss_count`;
    - go to IDLE.
- A fill, once started, always completes, even if `imemREN` drops or `imemaddr` changes. `fetch_addr` is held for the whole fill.
- In IDLE the frame is looked up again one cycle after the fill. If `imemaddr` still matches, it hits.
- `iaddr` equals `fetch_addr` in all states. `iREN=0` in IDLE.
- `flush`, in any state, clears every valid bit at the clock edge. `flush` does not reset the counters.
- `hit_count` increments on every cycle with `ihit=1`. Both counters wrap modulo 2^32.
- Reset (at a clock edge with `RST=1`) sets:
  - state IDLE, all valid bits 0;
  - `fetch_addr=0`;
  - `hit_count=0`, `miss_count=0`.
  - Tag and data arrays need not be cleared.
- Reset during FETCH abandons the fill. `iREN` is 0 from the next cycle, and the memory controller tolerates the dropped request.

## Timing
- Hit: 0-cycle latency. `ihit` is combinational from `imemaddr`, `imemREN` and the frame state.
- Miss: detect cycle, then `1 + W` FETCH cycles, where W is the number of `iwait=1` cycles, then a hit cycle. Total `ihit` latency = `W + 2` cycles after the miss cycle.
- Outputs after reset: `ihit=0`, `imemload=0`, `iREN=0`, `iaddr=0`, `hit_count=0`, `miss_count=0`.
- Frame writes become visible to the lookup on the cycle after the write edge. There is no write-to-read bypass.
- When `flush` and a hit condition occur in the same IDLE cycle, `flush` wins: `ihit=0` and no state change other than the invalidation.

## Test plan
- Reset, then `imemREN=1`, `imemaddr=0x0`:
  - required: `ihit=0`; next cycle `iREN=1`, `iaddr=0x0`.
  - Hold `iwait=1` for 2 cycles, then `iload=0x2001000A`.
  - required: `iREN=0` afterwards; following cycle `ihit=1`, `imemload=0x2001000A`, `miss_count=1`.
- After the above, hold `imemaddr=0x0` for 3 more cycles -> `ihit=1` every cycle; `hit_count=4`; `iREN` stays 0.
- Conflict with `SETS=16`:
  - Read `0x40` (index 0, new tag) -> miss, fill `0x8C220004`, `miss_count=2`.
  - Then read `0x0` -> miss again, `iaddr=0x0`.
- Fill `0x4`, then pulse `flush` for one cycle, then read `0x4`:
  - required: `ihit=0`, FETCH entered, `iaddr=0x4`.
  - `hit_count` is unchanged by the flush.
- Miss on `0x4`, then change `imemaddr` to `0x8` during FETCH with `iwait=1`:
  - required: `iaddr` stays `0x4` and frame 1 is filled.
  - Next IDLE cycle misses on `0x8`, `iaddr=0x8`.
- Assert `RST` mid-FETCH:
  - required next cycle: `iREN=0`, `iaddr=0`, `ihit=0`, counters 0.
  - A read of a previously filled address then misses.
